// File: rtl/gpio_bus_pkg.sv
// Shared types and address map for the 8-bit GPIO register bus initiator.
// Even addresses are read ports and odd addresses are write ports, for three banks.
package gpio_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        TURN,
        RESP
    } state_t;

    localparam logic [2:0] GPIO0_RD = 3'b000;
    localparam logic [2:0] GPIO0_WR = 3'b001;
    localparam logic [2:0] GPIO1_RD = 3'b010;
    localparam logic [2:0] GPIO1_WR = 3'b011;
    localparam logic [2:0] GPIO2_RD = 3'b100;
    localparam logic [2:0] GPIO2_WR = 3'b101;

    // The address is zero-extended by the caller so any bus width up to 32 bits works.
    function automatic logic addr_is_mapped(input logic write, input logic [31:0] addr);
        if (write) begin
            return (addr == 32'(GPIO0_WR)) || (addr == 32'(GPIO1_WR)) || (addr == 32'(GPIO2_WR));
        end
        return (addr == 32'(GPIO0_RD)) || (addr == 32'(GPIO1_RD)) || (addr == 32'(GPIO2_RD));
    endfunction

endpackage

// File: rtl/gpio_bus_master.sv
// Single-command initiator for the GPIO register bus: setup, strobe, turnaround, response.
// Bus-facing outputs double as the command latch; cmd_ready is the only decoded output.
module gpio_bus_master
    import gpio_bus_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] add_reg,
    output logic              r_en,
    output logic              w_en,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [3:0] CNT_LOAD = 4'(RD_WAIT - 1);

    state_t     state_reg;
    logic       write_reg;
    logic [3:0] cnt_reg;
    logic       cmd_mapped;

    assign cmd_ready  = (state_reg == IDLE);
    assign cmd_mapped = addr_is_mapped(cmd_write, 32'(cmd_addr));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            write_reg <= 1'b0;
            cnt_reg   <= '0;
            add_reg   <= '0;
            r_en      <= 1'b0;
            w_en      <= 1'b0;
            bus_oe    <= 1'b0;
            bus_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        write_reg <= cmd_write;
                        rsp_rdata <= '0;
                        if (cmd_mapped) begin
                            // Outputs registered here are what the bus sees during SETUP.
                            add_reg   <= cmd_addr;
                            bus_oe    <= cmd_write;
                            bus_wdata <= cmd_write ? cmd_wdata : '0;
                            rsp_err   <= 1'b0;
                            state_reg <= SETUP;
                        end else begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state_reg <= RESP;
                        end
                    end
                end
                SETUP: begin
                    cnt_reg   <= CNT_LOAD;
                    w_en      <= write_reg;
                    r_en      <= !write_reg;
                    state_reg <= ACCESS;
                end
                ACCESS: begin
                    if (write_reg) begin
                        w_en      <= 1'b0;
                        bus_oe    <= 1'b0;
                        state_reg <= TURN;
                    end else if (cnt_reg == 4'd0) begin
                        // Last r_en cycle: the registered read mux has settled by now.
                        r_en      <= 1'b0;
                        rsp_rdata <= bus_rdata;
                        state_reg <= TURN;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                TURN: begin
                    rsp_valid <= 1'b1;
                    state_reg <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_bus_master.sv
// Bench for gpio_bus_master: three instances (RD_WAIT 2, 1, 4), each with its own GPIO register model.
// Directed phase-timing checks on the RD_WAIT=2 instance, then random commands on the other two.
module tb_gpio_bus_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_write;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_ready;
    int         sel;

    logic       m_cmd_ready, m_rsp_valid, m_rsp_err, m_r_en, m_w_en, m_bus_oe;
    logic [7:0] m_rsp_rdata, m_bus_wdata;
    logic [2:0] m_add_reg;
    logic [24:0] obs_sel;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    int rsp_cnt = 0;

    logic       tr_w   [64];
    logic       tr_r   [64];
    logic       tr_oe  [64];
    logic [2:0] tr_add [64];
    logic [7:0] tr_wd  [64];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int RDW = (gi == 0) ? 2 : (gi == 1) ? 1 : 4;
        logic       cmd_ready, rsp_valid, rsp_err, r_en, w_en, bus_oe;
        logic [7:0] rsp_rdata, bus_wdata, bus_rdata;
        logic [2:0] add_reg;
        logic [7:0] mem [4];
        logic [24:0] obs;

        gpio_bus_master #(.RD_WAIT(RDW), .ADDR_W(3), .DATA_W(8)) u_dut (
            .clk       (clk),
            .reset     (rst_n),
            .cmd_valid (cmd_valid && (sel == gi)),
            .cmd_ready (cmd_ready),
            .cmd_write (cmd_write),
            .cmd_addr  (cmd_addr),
            .cmd_wdata (cmd_wdata),
            .rsp_valid (rsp_valid),
            .rsp_ready (rsp_ready && (sel == gi)),
            .rsp_rdata (rsp_rdata),
            .rsp_err   (rsp_err),
            .add_reg   (add_reg),
            .r_en      (r_en),
            .w_en      (w_en),
            .bus_wdata (bus_wdata),
            .bus_oe    (bus_oe),
            .bus_rdata (bus_rdata)
        );

        // GPIO register bank: addr[2:1] selects the port for both reads and writes.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
            end else if (w_en) begin
                mem[add_reg[2:1]] <= bus_wdata;
            end
        end

        if (RDW == 1) begin : g_comb_rd
            assign bus_rdata = r_en ? mem[add_reg[2:1]] : 8'h00;
        end else begin : g_reg_rd
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) bus_rdata <= 8'h00;
                else        bus_rdata <= r_en ? mem[add_reg[2:1]] : 8'h00;
            end
        end

        assign obs = {cmd_ready, rsp_valid, rsp_err, r_en, w_en, bus_oe, rsp_rdata, bus_wdata, add_reg};
    end

    always_comb begin
        case (sel)
            1:       obs_sel = g_inst[1].obs;
            2:       obs_sel = g_inst[2].obs;
            default: obs_sel = g_inst[0].obs;
        endcase
    end
    assign {m_cmd_ready, m_rsp_valid, m_rsp_err, m_r_en, m_w_en, m_bus_oe,
            m_rsp_rdata, m_bus_wdata, m_add_reg} = obs_sel;

    always @(negedge clk) begin
        if (m_r_en && m_w_en)   viol++;
        if (m_bus_oe && m_r_en) viol++;
    end

    always @(posedge clk) begin
        if (m_rsp_valid && rsp_ready) rsp_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_mapped(input bit wr, input logic [2:0] a);
        return (a <= 3'd5) && (a[0] == wr);
    endfunction

    // Issue one command, record the bus trace per cycle (cycle 1 = first after acceptance),
    // hold rsp_ready low for 'hold' response cycles, then complete the handshake.
    task automatic do_cmd(input bit wr, input logic [2:0] a, input logic [7:0] d, input int hold,
                          output logic [7:0] rd, output bit er, output int lat);
        int guard;
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        rsp_ready = (hold == 0);
        guard = 0;
        while (!m_cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_val("accept_to", guard < 50, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        while (1) begin
            tr_w[n]   = m_w_en;
            tr_r[n]   = m_r_en;
            tr_oe[n]  = m_bus_oe;
            tr_add[n] = m_add_reg;
            tr_wd[n]  = m_bus_wdata;
            if (m_rsp_valid || n >= 40) break;
            @(negedge clk);
            n++;
        end
        check_val("rsp_to", m_rsp_valid, 1);
        lat = n;
        rd  = m_rsp_rdata;
        er  = m_rsp_err;
        if (hold > 0) begin
            for (int i = 1; i < hold; i++) begin
                @(negedge clk);
                check_val("hold_valid", m_rsp_valid, 1);
                check_val("hold_rdata", m_rsp_rdata, rd);
                check_val("hold_busy", m_cmd_ready, 0);
            end
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check_val("rsp_clear", m_rsp_valid, 0);
        check_val("idle_ready", m_cmd_ready, 1);
    endtask

    task automatic run_random(input int s, input int rdw, input int ncmd);
        logic [7:0] model [4];
        logic [7:0] rd;
        logic [7:0] exp_rd;
        logic [2:0] a;
        logic [7:0] d;
        bit er, wr, mp;
        int lat, cw, cr, start_cnt;
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        sel = s;
        start_cnt = rsp_cnt;
        for (int k = 0; k < ncmd; k++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_cmd(wr, a, d, int'($urandom_range(0, 3)), rd, er, lat);
            mp = is_mapped(wr, a);
            exp_rd = (mp && !wr) ? model[a[2:1]] : 8'h00;
            check_val("rnd_lat", lat, !mp ? 1 : (wr ? 4 : 3 + rdw));
            check_val("rnd_err", er, !mp);
            check_val("rnd_rdata", rd, exp_rd);
            cw = 0;
            cr = 0;
            for (int c = 1; c <= lat; c++) begin
                cw += int'(tr_w[c]);
                cr += int'(tr_r[c]);
            end
            check_val("rnd_wen_cycles", cw, (mp && wr) ? 1 : 0);
            check_val("rnd_ren_cycles", cr, (mp && !wr) ? rdw : 0);
            if (mp && wr) model[a[2:1]] = d;
        end
        check_val("rsp_count", rsp_cnt - start_cnt, ncmd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic [2:0] unm [2];
        bit er;
        int lat, n, cnt;

        rst_n = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 3'b000;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b0;
        sel = 0;
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_cmd_ready", m_cmd_ready, 1);
        check_val("rst_rsp_valid", m_rsp_valid, 0);
        check_val("rst_r_en", m_r_en, 0);
        check_val("rst_w_en", m_w_en, 0);
        check_val("rst_bus_oe", m_bus_oe, 0);
        check_val("rst_add_reg", m_add_reg, 0);
        check_val("rst_bus_wdata", m_bus_wdata, 0);
        check_val("rst_rsp_rdata", m_rsp_rdata, 0);
        check_val("rst_rsp_err", m_rsp_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a read strobe.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 3'b000;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_val("abort_ren_pre", m_r_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_r_en", m_r_en, 0);
        check_val("abort_bus_oe", m_bus_oe, 0);
        check_val("abort_rsp_valid", m_rsp_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (m_rsp_valid) cnt++;
        end
        check_val("abort_no_rsp", cnt, 0);
        check_val("abort_ready", m_cmd_ready, 1);

        do_cmd(1'b1, 3'b001, 8'hA5, 0, rd, er, lat);
        $display("write addr=001 data=a5 lat=%0d err=%0d rdata=%0h", lat, er, rd);
        check_val("wr_lat", lat, 4);
        check_val("wr_err", er, 0);
        check_val("wr_rdata", rd, 0);
        for (int c = 1; c <= 4; c++) begin
            check_val("wr_w_en", tr_w[c], c == 2);
            check_val("wr_r_en", tr_r[c], 0);
            check_val("wr_bus_oe", tr_oe[c], c <= 2);
            check_val("wr_add_reg", tr_add[c], 3'b001);
            if (c <= 2) check_val("wr_bus_wdata", tr_wd[c], 8'hA5);
        end

        do_cmd(1'b1, 3'b011, 8'h3C, 0, rd, er, lat);
        do_cmd(1'b0, 3'b010, 8'h00, 0, rd, er, lat);
        $display("read addr=010 lat=%0d err=%0d rdata=%0h", lat, er, rd);
        check_val("rd_lat", lat, 5);
        check_val("rd_err", er, 0);
        check_val("rd_rdata", rd, 8'h3C);
        for (int c = 1; c <= 5; c++) begin
            check_val("rd_r_en", tr_r[c], (c == 2) || (c == 3));
            check_val("rd_w_en", tr_w[c], 0);
            check_val("rd_bus_oe", tr_oe[c], 0);
            check_val("rd_add_reg", tr_add[c], 3'b010);
        end

        unm[0] = 3'b110;
        unm[1] = 3'b000;
        for (int u = 0; u < 2; u++) begin
            do_cmd(1'b1, unm[u], 8'hFF, 0, rd, er, lat);
            $display("write addr=%b (unmapped) lat=%0d err=%0d rdata=%0h", unm[u], lat, er, rd);
            check_val("unm_lat", lat, 1);
            check_val("unm_err", er, 1);
            check_val("unm_rdata", rd, 0);
            check_val("unm_strobe", {tr_w[1], tr_r[1], tr_oe[1]}, 0);
        end

        // Slow consumer with a second command already waiting.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 3'b010;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_write = 1'b1;
        cmd_addr  = 3'b101;
        cmd_wdata = 8'h5A;
        n = 1;
        while (!m_rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("busy_lat", n, 5);
        for (int i = 0; i < 10; i++) begin
            check_val("busy_rsp_valid", m_rsp_valid, 1);
            check_val("busy_rsp_rdata", m_rsp_rdata, 8'h3C);
            check_val("busy_cmd_ready", m_cmd_ready, 0);
            if (i < 9) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_val("busy_rsp_clear", m_rsp_valid, 0);
        check_val("busy_idle_cycle", m_cmd_ready, 1);
        @(negedge clk);
        check_val("busy_second_taken", m_cmd_ready, 0);
        cmd_valid = 1'b0;
        n = 1;
        while (!m_rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("second_lat", n, 4);
        check_val("second_err", m_rsp_err, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        $display("busy read rdata=3c then write addr=101 data=5a lat=%0d", n);

        do_cmd(1'b0, 3'b100, 8'h00, 2, rd, er, lat);
        $display("read addr=100 lat=%0d err=%0d rdata=%0h", lat, er, rd);
        check_val("rd2_rdata", rd, 8'h5A);
        check_val("rd2_lat", lat, 5);

        run_random(1, 1, 500);
        $display("random run RD_WAIT=1 cmds=500 total=%0d bad=%0d", total, bad);
        run_random(2, 4, 500);
        $display("random run RD_WAIT=4 cmds=500 total=%0d bad=%0d", total, bad);

        check_val("strobe_rules", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
